// File: rtl/ballot_collector.sv
// Collects one yes/no vote from each of four voters and hands the 4-bit ballot downstream.
// Optional forced close of a stalled session is enabled by defining BALLOT_TIMEOUT_EN.
module ballot_collector #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       vote_valid,
    input  logic [1:0] vote_id,
    input  logic       vote_val,
    output logic       vote_ready,
    output logic       dup_err,
    output logic [3:0] ballot,
    output logic       ballot_valid,
    input  logic       ballot_ready,
    output logic [2:0] vote_count,
    output logic       timeout_flag,
    output logic       busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] PRESENT = 2'd2;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
        $error("ballot_collector: TIMEOUT out of range 1..65535");
    end

    logic [1:0] state;
    logic [3:0] mask;
    logic       accept;
    logic       dup;
    logic       last_vote;
    logic       expire;

    assign vote_ready   = (state == COLLECT);
    assign ballot_valid = (state == PRESENT);
    assign busy         = vote_ready | ballot_valid;
    assign accept       = vote_ready & vote_valid & ~mask[vote_id];
    assign dup          = vote_ready & vote_valid & mask[vote_id];
    // Three already recorded plus this one closes the session.
    assign last_vote    = accept & (vote_count == 3'd3);

`ifdef BALLOT_TIMEOUT_EN
    localparam int             CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] TO_MAX  = {CW{1'b1}};

    logic [CW-1:0] to_cnt;
    logic          tflag_q;

    // An accepted vote on the expiry edge wins over the timeout.
    assign expire       = vote_ready & ~accept & (to_cnt == TO_LAST);
    assign timeout_flag = tflag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt  <= '0;
            tflag_q <= 1'b0;
        end else begin
            if (((state == IDLE) && start) || accept)
                to_cnt <= '0;
            else if (vote_ready && (to_cnt != TO_MAX))
                to_cnt <= to_cnt + CW'(1);

            if ((state == IDLE) && start)
                tflag_q <= 1'b0;
            else if (expire)
                tflag_q <= 1'b1;
        end
    end
`else
    assign expire       = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ballot     <= 4'b0;
            mask       <= 4'b0;
            vote_count <= 3'd0;
            dup_err    <= 1'b0;
        end else begin
            dup_err <= dup;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= COLLECT;
                        ballot     <= 4'b0;
                        mask       <= 4'b0;
                        vote_count <= 3'd0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        ballot[vote_id] <= vote_val;
                        mask[vote_id]   <= 1'b1;
                        vote_count      <= vote_count + 3'd1;
                    end
                    if (last_vote || expire)
                        state <= PRESENT;
                end
                PRESENT: begin
                    if (ballot_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ballot_collector.sv
// Scoreboard bench for ballot_collector: directed scenarios followed by randomized traffic
// checked against a per-voter session model.
module tb_ballot_collector;

    localparam int TIMEOUT = 8;
`ifdef BALLOT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       vote_valid = 1'b0;
    logic [1:0] vote_id = 2'd0;
    logic       vote_val = 1'b0;
    logic       vote_ready;
    logic       dup_err;
    logic [3:0] ballot;
    logic       ballot_valid;
    logic       ballot_ready = 1'b0;
    logic [2:0] vote_count;
    logic       timeout_flag;
    logic       busy;

    ballot_collector #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vote_valid(vote_valid),
        .vote_id(vote_id), .vote_val(vote_val), .vote_ready(vote_ready),
        .dup_err(dup_err), .ballot(ballot), .ballot_valid(ballot_valid),
        .ballot_ready(ballot_ready), .vote_count(vote_count),
        .timeout_flag(timeout_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [3:0] b;
        int         c;
        logic       t;
    } exp_t;
    exp_t expq[$];

    // Session model: each voter either has not voted (-1) or holds 0/1.
    int m_vote[4] = '{-1, -1, -1, -1};
    bit m_col = 0, m_pre = 0, m_tf = 0, m_dup = 0, took = 0;
    int m_quiet = 0;

    function automatic logic [3:0] m_ballot();
        logic [3:0] b = 4'b0;
        for (int i = 0; i < 4; i++) b[i] = (m_vote[i] == 1);
        return b;
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 4; i++) if (m_vote[i] >= 0) n++;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_vote[i] = -1;
            m_col = 0; m_pre = 0; m_tf = 0; m_dup = 0; m_quiet = 0;
        end else begin
            m_dup = 0;
            if (m_pre) begin
                if (ballot_ready) m_pre = 0;
            end else if (m_col) begin
                took = 0;
                if (vote_valid) begin
                    if (m_vote[vote_id] < 0) begin
                        m_vote[vote_id] = int'(vote_val);
                        took = 1;
                    end else m_dup = 1;
                end
                if (took) m_quiet = 0; else m_quiet++;
                if (m_count() == 4 || (TO_EN && !took && m_quiet >= TIMEOUT)) begin
                    m_tf  = (m_count() != 4);
                    m_col = 0;
                    m_pre = 1;
                    expq.push_back('{b: m_ballot(), c: m_count(), t: m_tf});
                end
            end else if (start) begin
                for (int i = 0; i < 4; i++) m_vote[i] = -1;
                m_col = 1; m_tf = 0; m_quiet = 0;
            end
        end
    end

    // Monitor: per-cycle state checks, plus scoreboard pop on each new presentation.
    logic prev_bv = 1'b0;
    exp_t e;
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("vote_ready", vote_ready, m_col);
            chk("ballot_valid", ballot_valid, m_pre);
            chk("busy", busy, m_col | m_pre);
            chk("dup_err", dup_err, m_dup);
            chk("vote_count", vote_count, m_count());
            chk("ballot", ballot, m_ballot());
            chk("timeout_flag", timeout_flag, m_tf);
            if (ballot_valid && !prev_bv) begin
                if (expq.size() == 0) begin
                    chk("sb_unexpected_ballot", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("sb_ballot", ballot, e.b);
                    chk("sb_count", vote_count, e.c);
                    chk("sb_tflag", timeout_flag, e.t);
                end
            end
        end
        prev_bv = ballot_valid;
    end

    task automatic step(input logic st, input logic vv, input logic [1:0] id,
                        input logic val, input logic br);
        @(negedge clk);
        start = st; vote_valid = vv; vote_id = id; vote_val = val; ballot_ready = br;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        start = 0; vote_valid = 0; vote_id = 0; vote_val = 0; ballot_ready = 0;
        #1;
        chk("reset_outputs",
            {vote_ready, dup_err, ballot, ballot_valid, vote_count, timeout_flag, busy}, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    int  j;
    bit  seen;
    int  vv_pct;

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_state", {vote_ready, ballot_valid, busy, ballot, vote_count}, 0);
        #2 rst_n = 1'b1;

        // Four back-to-back votes
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 2, 1, 0);
        step(0, 1, 3, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("t1_valid", ballot_valid, 1);
        chk("t1_ballot", ballot, 4'b1101);
        chk("t1_count", vote_count, 4);
        chk("t1_tflag", timeout_flag, 0);
        step(0, 0, 0, 0, 1);

        // Duplicate offer for id3
        step(1, 0, 0, 0, 0);
        step(0, 1, 3, 1, 0);
        step(0, 1, 3, 0, 0);
        step(0, 1, 1, 1, 0);
        chk("t2_dup_pulse", dup_err, 1);
        step(0, 1, 0, 0, 0);
        chk("t2_dup_end", dup_err, 0);
        step(0, 1, 2, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("t2_ballot", ballot, 4'b1010);
        chk("t2_count", vote_count, 4);

        // Held presentation ignores start and votes
        for (int k = 0; k < 5; k++) begin
            step(1, 1, 2'(k), 1, 0);
            chk("t3_hold_ballot", ballot, 4'b1010);
            chk("t3_no_ready", vote_ready, 0);
        end
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        chk("t3_idle", busy, 0);
        step(0, 0, 0, 0, 0);
        chk("t3_restart", vote_ready, 1);

        // Reset mid-session, then a fresh all-yes session
        step(0, 1, 0, 1, 0);
        step(0, 1, 1, 1, 0);
        do_reset();
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 1, 2'(k), 1, 0);
        step(0, 0, 0, 0, 0);
        chk("t5_ballot", ballot, 4'b1111);
        step(0, 0, 0, 0, 1);

`ifdef BALLOT_TIMEOUT_EN
        step(1, 0, 0, 0, 0);
        step(0, 1, 2, 1, 0);
        seen = 0;
        for (j = 1; j <= 40 && !seen; j++) begin
            step(0, 0, 0, 0, 0);
            if (ballot_valid) seen = 1;
        end
        chk("to_latency", seen ? j - 2 : 999, TIMEOUT);
        chk("to_ballot", ballot, 4'b0100);
        chk("to_count", vote_count, 1);
        chk("to_flag", timeout_flag, 1);
        step(0, 0, 0, 0, 1);
`endif

        // Randomized traffic with alternating busy and quiet vote phases
        vv_pct = 80;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) vv_pct = ($urandom_range(0, 1) == 0) ? 85 : 8;
            if ($urandom_range(0, 799) == 0) do_reset();
            step($urandom_range(0, 3) == 0, $urandom_range(0, 99) < vv_pct,
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        repeat (3) step(0, 0, 0, 0, 0);
        chk("sb_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ballot_collector.md
# ballot_collector

Sequential front end for the four-voter majority logic: opens a voting session, collects one yes/no vote from each of four voters over a valid/ready port, and presents the completed 4-bit ballot to the downstream voter block through a valid/ready handshake. It rejects duplicate votes and can optionally close a stalled session by timeout, treating missing votes as "no".

## Interface
- TIMEOUT, 16: consecutive COLLECT cycles without an accepted vote before forced close; legal range 1..65535; used only with BALLOT_TIMEOUT_EN.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  open a session; sampled only in IDLE.
- vote_valid  input  1  a vote is offered.
- vote_id  input  2  voter index 0..3; selects ballot bit.
- vote_val  input  1  1 = yes, 0 = no.
- vote_ready  output  1  high exactly while in COLLECT.
- dup_err  output  1  one-cycle pulse: a vote was offered for an id that has already voted.
- ballot  output  4  ballot[i] = vote of voter i; 0 for voters that did not vote.
- ballot_valid  output  1  high exactly while in PRESENT.
- ballot_ready  input  1  downstream accepts the ballot.
- vote_count  output  3  accepted votes this session, 0..4.
- timeout_flag  output  1  session closed by timeout; valid with ballot.
- busy  output  1  high in COLLECT or PRESENT.

## Operation
- One clock domain; reset is asynchronous and active-low.
- States: IDLE, COLLECT, PRESENT. Reset to IDLE; all outputs 0; ballot, received-mask, vote_count and timeout counter cleared.
- IDLE: start=1 -> COLLECT; ballot, mask, vote_count, timeout counter and timeout_flag cleared on that edge. Other inputs ignored.
- COLLECT: a vote is accepted on an edge where vote_valid & vote_ready and mask[vote_id]=0: ballot[vote_id] <= vote_val, mask[vote_id] <= 1, vote_count += 1.
- Duplicate (mask[vote_id]=1): vote not recorded, vote_count unchanged, dup_err=1 the following cycle for one cycle; the timeout counter is not cleared.
- Fourth accepted vote -> PRESENT on the same edge.
- PRESENT: ballot, vote_count and timeout_flag held stable; vote_ready=0; start ignored. ballot_valid & ballot_ready -> IDLE; ballot retains its value in IDLE until the next start.
- Votes offered outside COLLECT are not consumed (vote_ready=0); the source holds them.
- Order of arrival is free; any permutation of ids yields the same ballot.

## Timing
- Vote acceptance: zero-cycle handshake; ballot/vote_count update visible the cycle after the accepting edge.
- start at edge N -> vote_ready=1 from cycle N+1.
- Fourth vote accepted at edge N -> ballot_valid=1 in cycle N+1 with the final ballot.
- Ballot accepted at edge N -> IDLE in cycle N+1; start may be asserted in N+1 and is taken at edge N+1.
- Timeout counter: cleared on COLLECT entry and on each accepted vote; increments on every other COLLECT edge. If it equals TIMEOUT-1 on an edge with no accepted vote -> PRESENT with timeout_flag=1. Without votes, ballot_valid rises TIMEOUT cycles after vote_ready rises.
- Accepted vote on the same edge the counter would expire: the vote wins, counter clears, no timeout.
- Counter width: $clog2(TIMEOUT+1) bits; saturates, never wraps.
- rst_n low at any time, including mid-session or during PRESENT: immediate return to IDLE with all outputs 0; a partial ballot is discarded.

## Configuration
- BALLOT_TIMEOUT_EN defined: timeout counter and forced close as specified; timeout_flag live.
- Not defined: no counter is built; COLLECT waits indefinitely for four votes; timeout_flag tied to 0; TIMEOUT ignored.

## Test plan
- Reset then start; votes (id0,1),(id1,0),(id2,1),(id3,1) back to back -> ballot=4'b1101, vote_count=4, ballot_valid the cycle after the fourth vote, timeout_flag=0.
- Votes id3=1, id3=0, id1=1, id0=0, id2=0 -> dup_err one pulse after the second offer, ballot=4'b1010, vote_count=4.
- BALLOT_TIMEOUT_EN, TIMEOUT=8: start, vote id2=1, then idle -> ballot_valid 8 cycles after that vote, ballot=4'b0100, vote_count=1, timeout_flag=1.
- Hold ballot_ready=0 for 5 cycles in PRESENT with start=1 and vote_valid=1 -> ballot stable, vote_ready=0, no new session; ballot_ready=1 -> IDLE next cycle, then start is accepted.
- Assert rst_n=0 after two accepted votes -> all outputs 0 asynchronously; after release, a fresh session of four votes id0..3=1 gives ballot=4'b1111.
